// File: rtl/pc_sequencer_pkg.sv
// Shared Hack CPU definitions: sequencer state encodings and
// instruction field positions used by the fetch/execute control.
package hack_cpu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RST   = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_EXEC  = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

  localparam int C_BIT      = 15;
  localparam int A_BIT      = 12;
  localparam int DEST_M_BIT = 3;
  localparam int JMP_LSB    = 0;

endpackage

// File: rtl/pc_sequencer_if.sv
// ROM fetch handshake: master raises rom_req (address = PC),
// slave returns rom_data qualified by rom_ack.
interface pc_sequencer_if #(
  parameter int W = 16
);
  logic         rom_req;
  logic         rom_ack;
  logic [W-1:0] rom_data;

  modport master (
    output rom_req,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    output rom_ack,
    output rom_data
  );
endinterface

// File: rtl/pc_sequencer_jump_cond.sv
// Hack C-instruction jump condition from j[2:0] and ALU flags.
// Ports: i_j (jump bits), i_zr/i_ng (ALU flags), o_jmp (take jump).
module hack_jump_cond (
  input  logic [2:0] i_j,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_jmp
);

  // j2: out<0, j1: out==0, j0: out>0
  assign o_jmp = (i_j[2] & i_ng)
               | (i_j[1] & i_zr)
               | (i_j[0] & ~i_ng & ~i_zr);

endmodule

// File: rtl/pc_sequencer.sv
// Hack CPU fetch/execute sequencer: ROM fetch, M-access stall,
// jump resolution, PC control and self-loop halt detection.
// Ports: clk/reset, rom (fetch handshake), instr/instr_valid,
// commit, ALU flags, mem_busy, a_value/pc_value, pc_* controls,
// halted.
module pc_sequencer
  import hack_cpu_pkg::*;
#(
  parameter int W           = 16,
  parameter bit HALT_DETECT = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.master rom,
  output logic [W-1:0]  instr,
  output logic          instr_valid,
  output logic          commit,
  input  logic          alu_zr,
  input  logic          alu_ng,
  input  logic          mem_busy,
  input  logic [W-1:0]  a_value,
  input  logic [W-1:0]  pc_value,
  output logic          pc_inc,
  output logic          pc_load,
  output logic          pc_reset,
  output logic          halted
);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_instr;

  logic         w_is_c;
  logic         w_stall;
  logic         w_go;
  logic         w_jmp;
  logic         w_take;
  logic         w_self;
  logic         w_halt;
  logic [2:0]   w_j;
  logic [W-1:0] w_pc_m1;

  assign w_is_c = r_instr[C_BIT];
  assign w_j    = r_instr[JMP_LSB +: 3];

  // Only C-instrs that read or write M wait on data memory
  assign w_stall = w_is_c & mem_busy
                 & (r_instr[A_BIT] | r_instr[DEST_M_BIT]);

  // Instruction completes this cycle
  assign w_go = ((r_state == ST_EXEC) & ~w_stall)
              | ((r_state == ST_WAIT) & ~mem_busy);

  hack_jump_cond u_jc (
    .i_j   (w_j),
    .i_zr  (alu_zr),
    .i_ng  (alu_ng),
    .o_jmp (w_jmp)
  );

  assign w_take = w_is_c & w_jmp;

  // "@END; 0;JMP": unconditional jump back to its own address
  assign w_pc_m1 = pc_value - {{(W-1){1'b0}}, 1'b1};
  assign w_self  = (a_value == w_pc_m1);
  assign w_halt  = HALT_DETECT & w_go & w_is_c
                 & (w_j == 3'b111) & w_self;

  assign commit  = w_go;
  assign pc_load = w_go & w_take;
  assign pc_inc  = w_go & ~w_take;

  assign rom.rom_req  = (r_state == ST_FETCH);
  assign instr_valid  = (r_state == ST_EXEC)
                      | (r_state == ST_WAIT);
  assign pc_reset     = (r_state == ST_RST);
  assign halted       = (r_state == ST_HALT);
  assign instr        = r_instr;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_RST:   w_next = ST_FETCH;
      ST_FETCH: if (rom.rom_ack) w_next = ST_EXEC;
      ST_EXEC: begin
        if (w_stall)     w_next = ST_WAIT;
        else if (w_halt) w_next = ST_HALT;
        else             w_next = ST_FETCH;
      end
      ST_WAIT: begin
        if (mem_busy)    w_next = ST_WAIT;
        else if (w_halt) w_next = ST_HALT;
        else             w_next = ST_FETCH;
      end
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RST;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_FETCH) && rom.rom_ack)
        r_instr <= rom.rom_data;
    end
  end

endmodule
